// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared instruction-memory geometry and program-loader states.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    localparam int          IMEM_ADDR_W = 12;
    localparam int          IMEM_DATA_W = 16;
    localparam int          IMEM_DEPTH  = 1 << IMEM_ADDR_W;
    localparam logic [7:0]  MAGIC_BYTE  = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ADDR_HI = 4'd1,
        ST_ADDR_LO = 4'd2,
        ST_LEN_HI  = 4'd3,
        ST_LEN_LO  = 4'd4,
        ST_DATA_HI = 4'd5,
        ST_DATA_LO = 4'd6,
        ST_CSUM    = 4'd7,
        ST_DONE    = 4'd8,
        ST_ERR     = 4'd9
    } loader_state_t;

endpackage : loader_pkg
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Framed byte-stream loader for the instruction memory; holds
//               the core in reset until a checksum-verified image is written.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W = IMEM_ADDR_W,
    parameter int         DATA_W = IMEM_DATA_W,
    parameter logic [7:0] MAGIC  = MAGIC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Range check is done wide enough that ADDR+LEN can never wrap.
    localparam int                 c_SUM_W = ((ADDR_W > 16) ? ADDR_W : 16) + 1;
    localparam logic [c_SUM_W-1:0] c_DEPTH = c_SUM_W'(2 ** ADDR_W);

    loader_state_t      r_state;
    loader_state_t      w_state_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_len_hi;
    logic [ADDR_W-1:0]  r_ptr;
    logic [15:0]        r_remaining;
    logic [7:0]         r_csum;
    logic [7:0]         r_hi;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;

    logic               w_accept;
    logic [15:0]        w_len;
    logic [c_SUM_W-1:0] w_end;
    logic               w_len_bad;
    logic               w_addr_hi_bad;

    assign w_accept      = rx_valid && rx_ready;
    assign w_len         = {r_len_hi, rx_data};
    assign w_end         = c_SUM_W'(r_addr) + c_SUM_W'(w_len);
    assign w_len_bad     = (w_len == 16'd0) || (w_end > c_DEPTH);
    assign w_addr_hi_bad = (rx_data >> (ADDR_W - 8)) != 8'd0;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (rx_data == MAGIC) begin
                        w_state_nxt = ST_ADDR_HI;
                    end
                end
                ST_ADDR_HI: w_state_nxt = w_addr_hi_bad ? ST_ERR : ST_ADDR_LO;
                ST_ADDR_LO: w_state_nxt = ST_LEN_HI;
                ST_LEN_HI:  w_state_nxt = ST_LEN_LO;
                ST_LEN_LO:  w_state_nxt = w_len_bad ? ST_ERR : ST_DATA_HI;
                ST_DATA_HI: w_state_nxt = ST_DATA_LO;
                ST_DATA_LO: w_state_nxt = (r_remaining == 16'd1) ? ST_CSUM : ST_DATA_HI;
                ST_CSUM: begin
                    w_state_nxt = ((r_csum ^ 8'h00) == rx_data) ? ST_DONE : ST_ERR;
                end
                ST_DONE:    w_state_nxt = ST_DONE;
                ST_ERR: begin
                    if (rx_data == MAGIC) begin
                        w_state_nxt = ST_ADDR_HI;
                    end
                end
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Header capture, write pointer, checksum and memory write port
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_len_hi    <= '0;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_csum      <= '0;
            r_hi        <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_accept) begin
                unique case (r_state)
                    ST_ADDR_HI: r_addr[ADDR_W-1:8] <= rx_data[ADDR_W-9:0];
                    ST_ADDR_LO: r_addr[7:0]        <= rx_data;
                    ST_LEN_HI:  r_len_hi           <= rx_data;
                    ST_LEN_LO: begin
                        if (!w_len_bad) begin
                            r_ptr       <= r_addr;
                            r_remaining <= w_len;
                            r_csum      <= 8'h00;
                        end
                    end
                    ST_DATA_HI: begin
                        r_hi   <= rx_data;
                        r_csum <= r_csum ^ rx_data;
                    end
                    ST_DATA_LO: begin
                        // Address/data stay put between strobes so the memory
                        // side never sees them change under a low mem_we.
                        r_csum      <= r_csum ^ rx_data;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_ptr;
                        r_mem_wdata <= DATA_W'({r_hi, rx_data});
                        r_ptr       <= r_ptr + 1'b1;
                        r_remaining <= r_remaining - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_ready  = reset && (r_state != ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign cpu_hold  = (r_state != ST_DONE);
    assign error     = (r_state == ST_ERR);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int r_n_cmp;
    int r_n_err;
    int r_cyc;
    int r_wr_cnt;
    logic [11:0] r_wr_addr [0:7];
    logic [15:0] r_wr_data [0:7];
    int          r_wr_cyc  [0:7];

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    // Write log, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            if (r_wr_cnt < 8) begin
                r_wr_addr[r_wr_cnt] = mem_addr;
                r_wr_data[r_wr_cnt] = mem_wdata;
                r_wr_cyc[r_wr_cnt]  = r_cyc;
            end
            r_wr_cnt = r_wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_n_cmp = r_n_cmp + 1;
        if (got !== exp) begin
            r_n_err = r_n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes [$], input bit gap);
        foreach (bytes[i]) send(bytes[i], gap);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk({tag, ".rx_ready"},  32'(rx_ready),  32'd0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, ".cpu_hold"},  32'(cpu_hold),  32'd1);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".error"},     32'(error),     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk({tag, ".ready_after_release"}, 32'(rx_ready), 32'd1);
        r_wr_cnt = 0;
    endtask

    logic [7:0] f1 [$];
    logic [7:0] fbad [$];
    logic [7:0] f5 [$];

    initial begin
        r_n_cmp  = 0;
        r_n_err  = 0;
        r_cyc    = 0;
        r_wr_cnt = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        f1   = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
        fbad = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
        f5   = '{8'hA5, 8'h0F, 8'hFE, 8'h00, 8'h02, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'h65};

        apply_reset("rst0");

        // Single word, with a check that the core is held until the checksum
        for (int i = 0; i < 7; i++) send(f1[i], 1'b0);
        @(negedge clk);
        chk("t1.hold_before_csum", 32'(cpu_hold), 32'd1);
        rx_data = f1[7];
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t1.done",     32'(done),     32'd1);
        chk("t1.cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t1.rx_ready", 32'(rx_ready), 32'd0);
        chk("t1.error",    32'(error),    32'd0);
        chk("t1.wr_cnt",   32'(r_wr_cnt), 32'd1);
        chk("t1.wr_addr",  32'(r_wr_addr[0]), 32'h010);
        chk("t1.wr_data",  32'(r_wr_data[0]), 32'h1234);
        chk("t1.addr_hold", 32'(mem_addr), 32'h010);
        chk("t1.data_hold", 32'(mem_wdata), 32'h1234);

        // Leading garbage, alternate-cycle gaps
        apply_reset("rst2");
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send_frame(f1, 1'b1);
        chk("t2.wr_cnt",  32'(r_wr_cnt), 32'd1);
        chk("t2.wr_addr", 32'(r_wr_addr[0]), 32'h010);
        chk("t2.wr_data", 32'(r_wr_data[0]), 32'h1234);
        chk("t2.done",    32'(done), 32'd1);

        // Bad checksum, then recovery
        apply_reset("rst3");
        send_frame(fbad, 1'b0);
        chk("t3.wr_cnt",   32'(r_wr_cnt), 32'd1);
        chk("t3.wr_addr",  32'(r_wr_addr[0]), 32'h010);
        chk("t3.error",    32'(error),    32'd1);
        chk("t3.cpu_hold", 32'(cpu_hold), 32'd1);
        chk("t3.done",     32'(done),     32'd0);
        chk("t3.rx_ready", 32'(rx_ready), 32'd1);
        send(8'h77, 1'b0);
        send(8'hA5, 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("t3.err_cleared", 32'(error), 32'd0);
        send_frame(f1[1:$], 1'b0);
        chk("t3.recover_done",  32'(done),  32'd1);
        chk("t3.recover_error", 32'(error), 32'd0);
        chk("t3.recover_wrs",   32'(r_wr_cnt), 32'd2);

        // Range and length errors
        apply_reset("rst4");
        send_frame('{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02}, 1'b0);
        chk("t4.range_err", 32'(error), 32'd1);
        send_frame('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
        chk("t4.len0_err", 32'(error), 32'd1);
        send_frame('{8'hA5, 8'h10}, 1'b0);
        chk("t4.addrhi_err", 32'(error), 32'd1);
        chk("t4.no_writes",  32'(r_wr_cnt), 32'd0);
        // Exactly reaching the top of memory is legal
        send_frame('{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h01, 8'h01}, 1'b0);
        chk("t4.edge_done",    32'(done), 32'd1);
        chk("t4.edge_wr_addr", 32'(r_wr_addr[0]), 32'hFFF);
        chk("t4.edge_wr_data", 32'(r_wr_data[0]), 32'h0001);

        // Multi-word back-to-back
        apply_reset("rst5");
        send_frame(f5, 1'b0);
        chk("t5.wr_cnt",   32'(r_wr_cnt), 32'd2);
        chk("t5.addr0",    32'(r_wr_addr[0]), 32'hFFE);
        chk("t5.data0",    32'(r_wr_data[0]), 32'hBEEF);
        chk("t5.addr1",    32'(r_wr_addr[1]), 32'hFFF);
        chk("t5.data1",    32'(r_wr_data[1]), 32'hCAFE);
        chk("t5.spacing",  32'(r_wr_cyc[1] - r_wr_cyc[0]), 32'd2);
        chk("t5.done",     32'(done), 32'd1);

        // Reset mid-data, then retransmit
        apply_reset("rst6a");
        for (int i = 0; i < 6; i++) send(f5[i], 1'b0);
        @(negedge clk);
        chk("t6.hold_mid", 32'(cpu_hold), 32'd1);
        apply_reset("t6.midreset");
        send_frame(f5, 1'b0);
        chk("t6.wr_cnt", 32'(r_wr_cnt), 32'd2);
        chk("t6.data1",  32'(r_wr_data[1]), 32'hCAFE);
        chk("t6.done",   32'(done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", r_n_cmp, r_n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prog_loader
`default_nettype wire

// File: doc/prog_loader.md
# prog_loader

Writer-side counterpart of the fetch path: receives a framed byte stream from the host link, assembles 16-bit instruction words, and writes them into the 4096×16 instruction memory that the fetch unit reads. It holds the processor in reset (`cpu_hold`) until a complete, checksum-verified program image has been written. After that it releases the core and goes quiet.

## Interface
Parameters:
- `ADDR_W`, 12, instruction memory address width (4096 words)
- `DATA_W`, 16, instruction word width
- `MAGIC`, 8'hA5, frame start byte

Ports:
- `clk`  in  1  single system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader can accept a byte
- `mem_we`  out  1  instruction memory write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  DATA_W  write data
- `cpu_hold`  out  1  keep fetch/core in reset while high
- `done`  out  1  sticky; image loaded and verified
- `error`  out  1  framing, range or checksum error

## Operation
- Byte accepted on a rising edge with `rx_valid && rx_ready`. No other edge changes state.
- Frame format:
  - `MAGIC`
  - ADDR_HI: bits [7:4] must be 0
  - ADDR_LO
  - LEN_HI
  - LEN_LO: LEN = word count
  - 2×LEN data bytes, high byte first
  - CSUM = XOR of all data bytes
- States: IDLE, ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR.
- **IDLE:** non-`MAGIC` bytes are discarded silently. `MAGIC` → ADDR_HI and clears `error`.
- **ADDR_HI:** nonzero upper nibble → ERR.
- **LEN_LO:** error check and initialisation.
  - LEN==0 or ADDR+LEN>4096 → ERR. The sum is computed 17 bits wide, so no wrap-around is possible. No memory writes occur.
  - Otherwise: write pointer ← ADDR, remaining ← LEN, checksum ← 0 → DATA_HI.
- **DATA_HI:** latch the high byte, XOR it into the checksum → DATA_LO.
- **DATA_LO:** XOR the byte into the checksum and issue a write of {hi, lo} at the write pointer. Then increment the pointer and decrement remaining. Remaining reaches 0 → CSUM, else → DATA_HI.
- **CSUM:**
  - Match → DONE.
  - Mismatch → ERR. Words already written stay in memory; `cpu_hold` stays high.
- **DONE:** `done`=1, `cpu_hold`=0, `rx_ready`=0. Terminal until reset.
- **ERR:** `error`=1, `rx_ready`=1. Bytes are discarded until `MAGIC`, which restarts the frame at ADDR_HI and clears `error`.
- `rx_ready`=1 in every state except DONE and while reset is asserted.

## Timing
- Reset values (asserted asynchronously):
  - `rx_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `cpu_hold`=1, `done`=0, `error`=0
  - state=IDLE
- First byte can be accepted on the first edge after reset is released; `rx_ready` is 1 from that point.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They are valid for exactly the one cycle following the DATA_LO handshake.
  - `mem_addr`/`mem_wdata` hold their last values when `mem_we`=0.
- Back-to-back bytes at one per cycle are supported with no bubbles. Gaps in `rx_valid` stall the FSM with no side effects.
- `done`, `cpu_hold` falling, and `error` rising all appear in the cycle after the deciding byte's handshake.
- Reset asserted mid-frame aborts immediately. A partial image may remain in memory, and `cpu_hold` returns to 1.

## Structure
- `loader_pkg`: state enum `loader_state_t`, `MAGIC_BYTE`, `IMEM_ADDR_W`, `IMEM_DATA_W`, `IMEM_DEPTH`. The fetch unit imports the same width constants.
- No sub-module. FSM, counters and checksum register live in one module.
- The instruction memory itself sits outside this block: in the top level, as a single-write-port / single-read-port array shared with fetch.

## Test plan
1. **Single word:** A5 00 10 00 01 12 34 26 → one `mem_we` pulse, addr 0x010, data 0x1234. `done`=1 and `cpu_hold`=0 one cycle after byte 26; `rx_ready`=0 afterwards.
2. **Leading garbage and gaps:** 00 FF then the frame from test 1, with `rx_valid` low on alternate cycles → identical single write; garbage produces no writes.
3. **Bad checksum:** test 1 frame with CSUM=00 → write to 0x010 occurs, `error`=1, `cpu_hold`=1, `done`=0. A following valid frame clears `error` and sets `done`.
4. **Range and length:**
   - A5 0F FF 00 02 → ERR after LEN_LO, zero writes.
   - A5 00 00 00 00 → ERR.
   - A5 10 00 … → ERR at ADDR_HI.
5. **Multi-word back-to-back:** addr 0xFFE, LEN 2, data 0xBEEF 0xCAFE, CSUM = BE^EF^CA^FE = 0x65 → writes at 0xFFE and 0xFFF in consecutive-pair cycles, then `done`.
6. **Reset mid-data:** assert reset after the first data byte of test 5 → all outputs return to reset values asynchronously. A full retransmitted frame then completes normally.
